// File: rtl/interp_dim_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// interp_dim_sequencer_pkg
// Shared definitions for the separable 2D interpolation control path:
//   - state encoding of the dimension sequencer
//   - fractional motion-vector width
//   - dimension-select constants matching the downstream mux
//     (DATA_IN_0 carries MV_Y, DATA_IN_1 carries MV_X)
// No ports; imported by interp_dim_sequencer and its row counter.
// -----------------------------------------------------------------------------
package interp_dim_sequencer_pkg;

    localparam int FRAC_W = 4;

    localparam logic SEL_Y = 1'b0;
    localparam logic SEL_X = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_HOR  = 3'd2,
        ST_VER  = 3'd3,
        ST_FIN  = 3'd4
    } state_e;

endpackage : interp_dim_sequencer_pkg

// File: rtl/interp_dim_sequencer_row_counter.sv
// -----------------------------------------------------------------------------
// interp_dim_sequencer_row_counter
// Row index counter for one filter pass.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous reset, active-high (count -> 0)
//   clr      in   synchronous clear, has priority over en
//   en       in   advance the count by one
//   term     in   terminal row index of the current pass
//   cnt      out  current row index (registered)
//   at_term  out  cnt equals term
// -----------------------------------------------------------------------------
module interp_dim_sequencer_row_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic [CNT_W-1:0] cnt,
    output logic             at_term
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign at_term = (cnt_q == term);

endmodule : interp_dim_sequencer_row_counter

// File: rtl/interp_dim_sequencer.sv
// -----------------------------------------------------------------------------
// interp_dim_sequencer
// Control stage ahead of the dimension-select mux of the separable 2D
// interpolator. Per request it captures the fractional MVs, runs a horizontal
// pass of BLK_H+TAPS-1 rows (SEL_DIM=1) and then a vertical pass of BLK_H
// rows (SEL_DIM=0), one row per non-stalled cycle, and pulses DONE.
// Every output is a flop; STALL sampled at an edge decides whether the
// following cycle issues a row.
//
// Optional feature macro: INTERP_SKIP_ZERO_FRAC_EN
//   defined   -> a pass whose fractional MV is zero is skipped
//   undefined -> both passes always run
//
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   asynchronous reset, active-high
//   START      in   request pulse, accepted only in IDLE
//   MV_X_FRAC  in   horizontal fractional MV, sampled on accepted START
//   MV_Y_FRAC  in   vertical fractional MV, sampled on accepted START
//   STALL      in   downstream not ready, freezes row sequencing
//   SEL_DIM    out  mux select, 1 = MV_X (horizontal pass)
//   MV_X_LSB   out  latched MV_X_FRAC (mux DATA_IN_1)
//   MV_Y_LSB   out  latched MV_Y_FRAC (mux DATA_IN_0)
//   ROW_CNT    out  row index within the current pass
//   ROW_VALID  out  a row is issued this cycle
//   BUSY       out  high in every state except IDLE
//   DONE       out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module interp_dim_sequencer
    import interp_dim_sequencer_pkg::*;
#(
    parameter int BLK_H = 8,
    parameter int TAPS  = 8,
    parameter int CNT_W = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [FRAC_W-1:0] MV_X_FRAC,
    input  logic [FRAC_W-1:0] MV_Y_FRAC,
    input  logic              STALL,
    output logic              SEL_DIM,
    output logic [FRAC_W-1:0] MV_X_LSB,
    output logic [FRAC_W-1:0] MV_Y_LSB,
    output logic [CNT_W-1:0]  ROW_CNT,
    output logic              ROW_VALID,
    output logic              BUSY,
    output logic              DONE
);

    localparam logic [CNT_W-1:0] TERM_HOR = CNT_W'(BLK_H + TAPS - 2);
    localparam logic [CNT_W-1:0] TERM_VER = CNT_W'(BLK_H - 1);

    state_e            state_q, state_d;
    logic [FRAC_W-1:0] mvx_q, mvx_d;
    logic [FRAC_W-1:0] mvy_q, mvy_d;
    logic              vld_q, vld_d;
    logic              sel_q, sel_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              row_clr;
    logic              row_en;
    logic [CNT_W-1:0]  row_term;
    logic [CNT_W-1:0]  row_cnt;
    logic              row_at_term;

    interp_dim_sequencer_row_counter #(
        .CNT_W (CNT_W)
    ) u_row_counter (
        .clk     (CLK),
        .rst     (RST),
        .clr     (row_clr),
        .en      (row_en),
        .term    (row_term),
        .cnt     (row_cnt),
        .at_term (row_at_term)
    );

    always_comb begin
        state_d  = state_q;
        mvx_d    = mvx_q;
        mvy_d    = mvy_q;
        row_clr  = 1'b0;
        row_en   = 1'b0;
        row_term = (state_q == ST_VER) ? TERM_VER : TERM_HOR;

        case (state_q)
            ST_IDLE: begin
                row_clr = 1'b1;
                if (START) begin
                    state_d = ST_LOAD;
                    mvx_d   = MV_X_FRAC;
                    mvy_d   = MV_Y_FRAC;
                end
            end
            ST_LOAD: begin
                row_clr = 1'b1;
                state_d = ST_HOR;
`ifdef INTERP_SKIP_ZERO_FRAC_EN
                if (mvx_q == '0) begin
                    state_d = (mvy_q == '0) ? ST_FIN : ST_VER;
                end
`endif
            end
            ST_HOR: begin
                // vld_q marks that the row at row_cnt went out this cycle;
                // only then may the pass advance.
                if (vld_q) begin
                    if (row_at_term) begin
                        row_clr = 1'b1;
                        state_d = ST_VER;
`ifdef INTERP_SKIP_ZERO_FRAC_EN
                        if (mvy_q == '0) begin
                            state_d = ST_FIN;
                        end
`endif
                    end else begin
                        row_en = 1'b1;
                    end
                end
            end
            ST_VER: begin
                if (vld_q) begin
                    if (row_at_term) begin
                        row_clr = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        row_en = 1'b1;
                    end
                end
            end
            ST_FIN: begin
                row_clr = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                row_clr = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        // Registered outputs describe the cycle that follows this edge.
        vld_d  = ((state_d == ST_HOR) || (state_d == ST_VER)) && !STALL;
        sel_d  = (state_d == ST_HOR) ? SEL_X : SEL_Y;
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FIN);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            mvx_q   <= '0;
            mvy_q   <= '0;
            vld_q   <= 1'b0;
            sel_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mvx_q   <= mvx_d;
            mvy_q   <= mvy_d;
            vld_q   <= vld_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign SEL_DIM   = sel_q;
    assign MV_X_LSB  = mvx_q;
    assign MV_Y_LSB  = mvy_q;
    assign ROW_CNT   = row_cnt;
    assign ROW_VALID = vld_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;

endmodule : interp_dim_sequencer

// File: tb/tb_interp_dim_sequencer.sv
// -----------------------------------------------------------------------------
// tb_interp_dim_sequencer
// Self-checking bench for interp_dim_sequencer. The expected trace of each
// request is generated from an ordered list of rows to issue (horizontal rows
// then vertical rows) and a per-cycle stall pattern: a cycle either issues
// the next row of the list or, when stalled, shows that row with ROW_VALID=0.
// -----------------------------------------------------------------------------
module tb_interp_dim_sequencer;

    localparam int BLK_H = 8;
    localparam int TAPS  = 8;
    localparam int CNT_W = 5;

    logic             CLK;
    logic             RST;
    logic             START;
    logic [3:0]       MV_X_FRAC;
    logic [3:0]       MV_Y_FRAC;
    logic             STALL;
    logic             SEL_DIM;
    logic [3:0]       MV_X_LSB;
    logic [3:0]       MV_Y_LSB;
    logic [CNT_W-1:0] ROW_CNT;
    logic             ROW_VALID;
    logic             BUSY;
    logic             DONE;

    int checks;
    int errors;

    interp_dim_sequencer #(
        .BLK_H (BLK_H),
        .TAPS  (TAPS),
        .CNT_W (CNT_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .MV_X_FRAC (MV_X_FRAC),
        .MV_Y_FRAC (MV_Y_FRAC),
        .STALL     (STALL),
        .SEL_DIM   (SEL_DIM),
        .MV_X_LSB  (MV_X_LSB),
        .MV_Y_LSB  (MV_Y_LSB),
        .ROW_CNT   (ROW_CNT),
        .ROW_VALID (ROW_VALID),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic e_sel, input logic [3:0] e_x,
                               input logic [3:0] e_y, input int e_cnt, input logic e_vld,
                               input logic e_busy, input logic e_done);
        chk({tag, ".sel"},  {31'd0, SEL_DIM},   {31'd0, e_sel});
        chk({tag, ".mvx"},  {28'd0, MV_X_LSB},  {28'd0, e_x});
        chk({tag, ".mvy"},  {28'd0, MV_Y_LSB},  {28'd0, e_y});
        chk({tag, ".cnt"},  {27'd0, ROW_CNT},   e_cnt);
        chk({tag, ".vld"},  {31'd0, ROW_VALID}, {31'd0, e_vld});
        chk({tag, ".busy"}, {31'd0, BUSY},      {31'd0, e_busy});
        chk({tag, ".done"}, {31'd0, DONE},      {31'd0, e_done});
    endtask

    // mode: 0 = no stall, 1 = stall while row 3 of the horizontal pass is
    // pending for four cycles, 2 = random stalls. abort: reset the block
    // while vertical row 4 is on the outputs. exp_done: required DONE cycle
    // counted from the accepting edge (negative = not checked).
    task automatic run_txn(input logic [3:0] mx, input logic [3:0] my, input int mode,
                           input bit abort, input int exp_done);
        bit   stl [0:255];
        int   q_dim [$];
        int   q_idx [$];
        int   nh, nv, c;
        bit   done_seen;
        logic e_sel, e_vld, e_busy, e_done;
        int   e_cnt;

        nh = BLK_H + TAPS - 1;
        nv = BLK_H;
`ifdef INTERP_SKIP_ZERO_FRAC_EN
        if (mx == 4'd0) nh = 0;
        if (my == 4'd0) nv = 0;
`endif
        for (int i = 0; i < nh; i++) begin q_dim.push_back(1); q_idx.push_back(i); end
        for (int i = 0; i < nv; i++) begin q_dim.push_back(0); q_idx.push_back(i); end

        for (int i = 0; i < 256; i++) begin
            stl[i] = (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (mode == 1 && i >= 5 && i <= 8) stl[i] = 1'b1;
        end

        START     = 1'b1;
        MV_X_FRAC = mx;
        MV_Y_FRAC = my;
        STALL     = stl[1];
        c         = 0;
        done_seen = 1'b0;

        while (!done_seen && c < 200) begin
            @(negedge CLK);
            c++;
            e_busy = 1'b1;
            e_done = 1'b0;
            e_vld  = 1'b0;
            e_sel  = 1'b0;
            e_cnt  = 0;
            if (c == 1) begin
                // load cycle: nothing issued yet
            end else if (q_dim.size() > 0) begin
                e_sel = q_dim[0][0];
                e_cnt = q_idx[0];
                if (!stl[c]) begin
                    e_vld = 1'b1;
                    void'(q_dim.pop_front());
                    void'(q_idx.pop_front());
                end
            end else begin
                e_done    = 1'b1;
                done_seen = 1'b1;
            end
            chk_outputs("txn", e_sel, mx, my, e_cnt, e_vld, e_busy, e_done);

            if (abort && c > 1 && !done_seen && e_sel == 1'b0 && e_cnt == 4) begin
                RST = 1'b1;
                #1;
                chk_outputs("abort_async", 1'b0, 4'd0, 4'd0, 0, 1'b0, 1'b0, 1'b0);
                START = 1'b0;
                STALL = 1'b0;
                @(posedge CLK);
                @(negedge CLK);
                RST = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge CLK);
                    chk_outputs("abort_idle", 1'b0, 4'd0, 4'd0, 0, 1'b0, 1'b0, 1'b0);
                end
                return;
            end

            START = 1'b0;
            if (c == 10) begin
                START     = 1'b1;
                MV_X_FRAC = 4'd9;
                MV_Y_FRAC = 4'($urandom_range(0, 15));
            end else if (done_seen) begin
                START     = 1'b1;
                MV_X_FRAC = 4'($urandom_range(0, 15));
                MV_Y_FRAC = 4'($urandom_range(0, 15));
            end
            STALL = (c + 1 < 256) ? stl[c + 1] : 1'b0;
        end

        if (!done_seen) chk("timeout", 32'd0, 32'd1);
        if (exp_done >= 0) chk("done_cycle", c, exp_done);

        @(negedge CLK);
        chk_outputs("post_idle0", 1'b0, mx, my, 0, 1'b0, 1'b0, 1'b0);
        START = 1'b0;
        STALL = 1'b0;
        @(negedge CLK);
        chk_outputs("post_idle1", 1'b0, mx, my, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        RST       = 1'b1;
        START     = 1'b0;
        STALL     = 1'b0;
        MV_X_FRAC = 4'd0;
        MV_Y_FRAC = 4'd0;

        repeat (3) @(negedge CLK);
        chk_outputs("in_reset", 1'b0, 4'd0, 4'd0, 0, 1'b0, 1'b0, 1'b0);
        RST = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            chk_outputs("reset_idle", 1'b0, 4'd0, 4'd0, 0, 1'b0, 1'b0, 1'b0);
        end

        run_txn(4'd5, 4'd11, 0, 1'b0, 25);
        run_txn(4'd5, 4'd11, 1, 1'b0, 29);
        run_txn(4'd5, 4'd11, 0, 1'b1, -1);
        run_txn(4'd3, 4'd7,  0, 1'b0, 25);

        for (int t = 0; t < 6; t++) begin
            run_txn(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2, 1'b0, -1);
        end

`ifdef INTERP_SKIP_ZERO_FRAC_EN
        run_txn(4'd0, 4'd8, 0, 1'b0, 10);
        run_txn(4'd6, 4'd0, 0, 1'b0, 17);
        run_txn(4'd0, 4'd0, 0, 1'b0, 2);
`else
        run_txn(4'd0, 4'd8, 0, 1'b0, 25);
        run_txn(4'd0, 4'd0, 0, 1'b0, 25);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_interp_dim_sequencer
